wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_fifo.sv | 47 ++++
 rtl/wb_arbiter.sv | 118 +++++++++++
 tb/tb_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and default constants for the register-file writeback arbiter.
// A queued slow-path result is a {destination, data} pair.
package wb_arbiter_pkg;

    localparam int WB_WIDTH        = 32;
    localparam int WB_DEPTH        = 32;
    localparam int WB_AW           = $clog2(WB_DEPTH);
    localparam int WB_QDEPTH       = 2;
    localparam int WB_STARVE_LIMIT = 4;

    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_AW-1:0]    rd;
        logic [WB_WIDTH-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of slow-path writeback entries.
// Pointers carry one extra bit so that full and empty are distinct.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int QDEPTH = WB_QDEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PW = $clog2(QDEPTH);

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    wb_entry_t   r_mem [QDEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges the ALU and slow writeback paths onto the single register-file write port,
// and tracks pending slow destinations for decode RAW checks.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH        = WB_WIDTH,
    parameter int DEPTH        = WB_DEPTH,
    parameter int QDEPTH       = WB_QDEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_wd,
    output logic             alu_stall,
    input  logic             slow_valid,
    output logic             slow_ready,
    input  logic [AW-1:0]    slow_rd,
    input  logic [WIDTH-1:0] slow_wd,
    input  logic             iss_valid,
    input  logic             iss_slow,
    input  logic [AW-1:0]    iss_rd,
    input  logic [AW-1:0]    q_rs1,
    input  logic [AW-1:0]    q_rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rf_we,
    output logic [AW-1:0]    rf_rd,
    output logic [WIDTH-1:0] rf_wd
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t        w_slow_in;
    wb_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_alu_wr;
    logic [CW-1:0]    w_cnt_nxt;
    logic [DEPTH-1:0] w_pend_nxt;

    logic [CW-1:0]    r_cnt;
    logic             r_alu_stall;
    logic [DEPTH-1:0] r_pending;
    logic             r_rf_we;
    logic [AW-1:0]    r_rf_rd;
    logic [WIDTH-1:0] r_rf_wd;

    assign w_slow_in = '{rd: slow_rd, wd: slow_wd};
    assign w_push    = slow_valid && !w_full;
    assign w_alu_wr  = alu_valid && !r_alu_stall && (alu_rd != REG_ZERO);
    assign w_pop     = !w_alu_wr && !w_empty;

    wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_slow_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Counts cycles a queued entry loses to the ALU; any pop resets it.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_empty || w_pop) w_cnt_nxt = '0;
        else if (w_alu_wr)    w_cnt_nxt = r_cnt + CW'(1);
    end

    // A newer slow issue to the same rd outranks the retiring older one.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_pop && (w_head.rd != REG_ZERO)) w_pend_nxt[w_head.rd] = 1'b0;
        if (iss_valid && iss_slow && (iss_rd != REG_ZERO)) w_pend_nxt[iss_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_alu_stall <= 1'b0;
            r_pending   <= '0;
            r_rf_we     <= 1'b0;
            r_rf_rd     <= '0;
            r_rf_wd     <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_alu_stall <= (w_cnt_nxt == CW'(STARVE_LIMIT));
            r_pending   <= w_pend_nxt;
            if (w_alu_wr) begin
                r_rf_we <= 1'b1;
                r_rf_rd <= alu_rd;
                r_rf_wd <= alu_wd;
            end else if (w_pop) begin
                r_rf_we <= (w_head.rd != REG_ZERO);
                r_rf_rd <= w_head.rd;
                r_rf_wd <= w_head.wd;
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign alu_stall  = r_alu_stall;
    assign slow_ready = !w_full;
    assign rs1_busy   = r_pending[q_rs1];
    assign rs2_busy   = r_pending[q_rs2];
    assign rf_we      = r_rf_we;
    assign rf_rd      = r_rf_rd;
    assign rf_wd      = r_rf_wd;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single-cycle behaviour,
// then hand sequences for starvation and asynchronous reset mid-stream.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        alu_stall;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_rd;
    logic [31:0] slow_wd;
    logic        iss_valid;
    logic        iss_slow;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    int n_vec;
    int n_err;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_wd     (alu_wd),
        .alu_stall  (alu_stall),
        .slow_valid (slow_valid),
        .slow_ready (slow_ready),
        .slow_rd    (slow_rd),
        .slow_wd    (slow_wd),
        .iss_valid  (iss_valid),
        .iss_slow   (iss_slow),
        .iss_rd     (iss_rd),
        .q_rs1      (q_rs1),
        .q_rs2      (q_rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] swd;
        logic        is;
        logic [4:0]  ird;
        logic [4:0]  q;
        logic        b;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rdy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] awd,
                                logic sv, logic [4:0] srd, logic [31:0] swd,
                                logic is, logic [4:0] ird, logic [4:0] q, logic b,
                                logic we, logic [4:0] rd, logic [31:0] wd, logic rdy);
        vec_t v;
        v.av = av; v.ard = ard; v.awd = awd;
        v.sv = sv; v.srd = srd; v.swd = swd;
        v.is = is; v.ird = ird; v.q = q; v.b = b;
        v.we = we; v.rd = rd; v.wd = wd; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        slow_valid = 0; slow_rd = 0; slow_wd = 0;
        iss_valid = 0; iss_slow = 0; iss_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        idle_inputs();
        q_rs1 = 0;
        q_rs2 = 0;

        //        av ard  awd           sv srd swd           is ird q   b  we rd  wd            rdy
        vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0,  0,            0, 0,  0,  0, 1, 5,  32'hDEADBEEF, 1));
        vt.push_back(mk(1, 0, 32'h11111111, 0, 0,  0,            0, 0,  0,  0, 0, 0,  0,            1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            1, 7,  7,  0, 0, 0,  0,            1));
        vt.push_back(mk(0, 0, 0,            1, 7,  32'h12345678, 0, 0,  7,  1, 0, 0,  0,            1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  7,  1, 1, 7,  32'h12345678, 1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  7,  0, 0, 0,  0,            1));
        vt.push_back(mk(0, 0, 0,            1, 3,  32'h33,       1, 3,  3,  0, 0, 0,  0,            1));
        vt.push_back(mk(1, 4, 32'h44,       0, 0,  0,            0, 0,  3,  1, 1, 4,  32'h44,       1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  3,  1, 1, 3,  32'h33,       1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  3,  0, 0, 0,  0,            1));
        vt.push_back(mk(1, 1, 32'hA1,       1, 10, 32'hB0,       0, 0,  0,  0, 1, 1,  32'hA1,       1));
        vt.push_back(mk(1, 2, 32'hA2,       1, 11, 32'hB1,       0, 0,  0,  0, 1, 2,  32'hA2,       0));
        vt.push_back(mk(1, 3, 32'hA3,       1, 12, 32'hB2,       0, 0,  0,  0, 1, 3,  32'hA3,       0));
        vt.push_back(mk(0, 0, 0,            1, 12, 32'hB2,       0, 0,  0,  0, 1, 10, 32'hB0,       1));
        vt.push_back(mk(0, 0, 0,            1, 12, 32'hB2,       0, 0,  0,  0, 1, 11, 32'hB1,       1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  0,  0, 1, 12, 32'hB2,       1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  0,  0, 0, 0,  0,            1));
        vt.push_back(mk(0, 0, 0,            1, 0,  32'h5,        0, 0,  0,  0, 0, 0,  0,            1));
        vt.push_back(mk(0, 0, 0,            0, 0,  0,            0, 0,  0,  0, 0, 0,  0,            1));

        #2;
        chk("reset rf_we", 64'(rf_we), 64'd0);
        chk("reset rf_rd", 64'(rf_rd), 64'd0);
        chk("reset rf_wd", 64'(rf_wd), 64'd0);
        chk("reset slow_ready", 64'(slow_ready), 64'd1);
        chk("reset alu_stall", 64'(alu_stall), 64'd0);
        chk("reset rs1_busy", 64'(rs1_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_wd = vt[i].awd;
            slow_valid = vt[i].sv; slow_rd = vt[i].srd; slow_wd = vt[i].swd;
            iss_valid = vt[i].is; iss_slow = vt[i].is; iss_rd = vt[i].ird;
            q_rs1 = vt[i].q; q_rs2 = vt[i].q;
            #1;
            chk($sformatf("v%0d rs1_busy", i), 64'(rs1_busy), 64'(vt[i].b));
            chk($sformatf("v%0d rs2_busy", i), 64'(rs2_busy), 64'(vt[i].b));
            tick();
            chk($sformatf("v%0d rf_we", i), 64'(rf_we), 64'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("v%0d rf_rd", i), 64'(rf_rd), 64'(vt[i].rd));
                chk($sformatf("v%0d rf_wd", i), 64'(rf_wd), 64'(vt[i].wd));
            end
            chk($sformatf("v%0d slow_ready", i), 64'(slow_ready), 64'(vt[i].rdy));
            chk($sformatf("v%0d alu_stall", i), 64'(alu_stall), 64'd0);
        end

        // Starvation: rd=9 queued while the ALU writes every cycle.
        idle_inputs();
        slow_valid = 1; slow_rd = 9; slow_wd = 32'h99;
        iss_valid = 1; iss_slow = 1; iss_rd = 9;
        q_rs1 = 9; q_rs2 = 0;
        tick();
        chk("starve push rf_we", 64'(rf_we), 64'd0);
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1; alu_rd = 5'(k); alu_wd = 32'(k * 16);
            tick();
            chk($sformatf("starve alu%0d rf_rd", k), 64'(rf_rd), 64'(k));
            chk($sformatf("starve alu%0d rf_we", k), 64'(rf_we), 64'd1);
            chk($sformatf("starve alu%0d alu_stall", k), 64'(alu_stall), 64'(k == 4));
        end
        chk("starve busy before slot", 64'(rs1_busy), 64'd1);
        alu_valid = 1; alu_rd = 5; alu_wd = 32'h55;
        tick();
        chk("stall slot rf_we", 64'(rf_we), 64'd1);
        chk("stall slot rf_rd", 64'(rf_rd), 64'd9);
        chk("stall slot rf_wd", 64'(rf_wd), 64'h99);
        chk("stall slot alu_stall", 64'(alu_stall), 64'd0);
        chk("stall slot busy cleared", 64'(rs1_busy), 64'd0);
        alu_valid = 1; alu_rd = 6; alu_wd = 32'h66;
        tick();
        chk("after stall rf_rd", 64'(rf_rd), 64'd6);
        chk("after stall alu_stall", 64'(alu_stall), 64'd0);

        // Asynchronous reset with two queued entries and pending bits set.
        idle_inputs();
        alu_valid = 1; alu_rd = 1; alu_wd = 32'hA1;
        slow_valid = 1; slow_rd = 20; slow_wd = 32'hC0;
        iss_valid = 1; iss_slow = 1; iss_rd = 20;
        tick();
        alu_valid = 1; alu_rd = 2; alu_wd = 32'hA2;
        slow_valid = 1; slow_rd = 21; slow_wd = 32'hC1;
        iss_valid = 1; iss_slow = 1; iss_rd = 21;
        tick();
        chk("prerst rf_rd", 64'(rf_rd), 64'd2);
        chk("prerst slow_ready", 64'(slow_ready), 64'd0);
        idle_inputs();
        q_rs1 = 20; q_rs2 = 21;
        #1;
        chk("prerst rs1_busy", 64'(rs1_busy), 64'd1);
        chk("prerst rs2_busy", 64'(rs2_busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst rf_we", 64'(rf_we), 64'd0);
        chk("midrst rf_rd", 64'(rf_rd), 64'd0);
        chk("midrst rf_wd", 64'(rf_wd), 64'd0);
        chk("midrst slow_ready", 64'(slow_ready), 64'd1);
        chk("midrst rs1_busy", 64'(rs1_busy), 64'd0);
        chk("midrst rs2_busy", 64'(rs2_busy), 64'd0);
        chk("midrst alu_stall", 64'(alu_stall), 64'd0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("postrst%0d rf_we", k), 64'(rf_we), 64'd0);
            chk($sformatf("postrst%0d slow_ready", k), 64'(slow_ready), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
